// File: rtl/rc4_phase_controller.sv
// RC4 phase sequencer: runs S init, KSA and PRGA in order, hands the single-port
// S memory to exactly one phase at a time and aborts any phase that overruns.
module rc4_phase_controller #(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd4095
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   output logic       sub_reset,
   output logic       init_start,
   output logic       ksa_start,
   output logic       prga_start,
   input  logic       init_done,
   input  logic       ksa_done,
   input  logic       prga_done,
   input  logic       init_wren,
   input  logic       ksa_wren,
   input  logic       prga_wren,
   input  logic [7:0] init_address,
   input  logic [7:0] ksa_address,
   input  logic [7:0] prga_address,
   input  logic [7:0] init_data,
   input  logic [7:0] ksa_data,
   input  logic [7:0] prga_data,
   output logic       mem_wren,
   output logic [7:0] mem_address,
   output logic [7:0] mem_data,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_INIT  = 3'd2,
      S_KSA   = 3'd3,
      S_PRGA  = 3'd4,
      S_DONE  = 3'd5,
      S_ERROR = 3'd6
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_cnt;
   logic        w_run;
   logic        w_cur_done;
   logic        w_timeout;

   assign w_run = (r_state == S_INIT) || (r_state == S_KSA) || (r_state == S_PRGA);

   // Only the running phase's done is looked at; stale dones from earlier phases are ignored.
   always_comb begin
      w_cur_done = 1'b0;
      case (r_state)
         S_INIT:  w_cur_done = init_done;
         S_KSA:   w_cur_done = ksa_done;
         S_PRGA:  w_cur_done = prga_done;
         default: w_cur_done = 1'b0;
      endcase
   end

   // Fires in the phase's TIMEOUT_CYCLES-th cycle; a saturated counter keeps it asserted.
   assign w_timeout = (TIMEOUT_CYCLES != 16'd0) &&
                      (({1'b0, r_cnt} + 17'd1) >= {1'b0, TIMEOUT_CYCLES});

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_CLEAR;
         S_CLEAR: w_next = S_INIT;
         S_INIT:  if (w_cur_done) w_next = S_KSA;  else if (w_timeout) w_next = S_ERROR;
         S_KSA:   if (w_cur_done) w_next = S_PRGA; else if (w_timeout) w_next = S_ERROR;
         S_PRGA:  if (w_cur_done) w_next = S_DONE; else if (w_timeout) w_next = S_ERROR;
         S_DONE:  if (start) w_next = S_CLEAR;
         S_ERROR: if (start) w_next = S_CLEAR;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 16'd0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state)
            r_cnt <= 16'd0;
         else if (w_run && (r_cnt != 16'hFFFF))
            r_cnt <= r_cnt + 16'd1;
      end
   end

   assign sub_reset  = (r_state == S_IDLE) || (r_state == S_CLEAR);
   assign init_start = (r_state == S_INIT);
   assign ksa_start  = (r_state == S_KSA);
   assign prga_start = (r_state == S_PRGA);
   assign busy       = (r_state == S_CLEAR) || w_run;
   assign done       = (r_state == S_DONE);
   assign error      = (r_state == S_ERROR);
   assign phase      = r_state;

   always_comb begin
      mem_wren    = 1'b0;
      mem_address = 8'd0;
      mem_data    = 8'd0;
      case (r_state)
         S_INIT: begin
            mem_wren    = init_wren;
            mem_address = init_address;
            mem_data    = init_data;
         end
         S_KSA: begin
            mem_wren    = ksa_wren;
            mem_address = ksa_address;
            mem_data    = ksa_data;
         end
         S_PRGA: begin
            mem_wren    = prga_wren;
            mem_address = prga_address;
            mem_data    = prga_data;
         end
         default: begin
            mem_wren    = 1'b0;
            mem_address = 8'd0;
            mem_data    = 8'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_rc4_phase_controller.sv
// Directed bench for rc4_phase_controller: a default-timeout instance for sequencing
// and muxing, plus a TIMEOUT_CYCLES=16 instance for the watchdog.
module tb_rc4_phase_controller;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;
   logic       start;
   logic       init_wren, ksa_wren, prga_wren;
   logic [7:0] init_address, ksa_address, prga_address;
   logic [7:0] init_data, ksa_data, prga_data;

   // main instance
   logic       sub_reset, init_start, ksa_start, prga_start;
   logic       init_done, ksa_done, prga_done;
   logic       mem_wren, busy, done, error;
   logic [7:0] mem_address, mem_data;
   logic [2:0] phase;

   // watchdog instance
   logic       wd_sub_reset, wd_init_start, wd_ksa_start, wd_prga_start;
   logic       wd_init_done, wd_ksa_done, wd_prga_done;
   logic       wd_mem_wren, wd_busy, wd_done, wd_error;
   logic [7:0] wd_mem_address, wd_mem_data;
   logic [2:0] wd_phase;

   // phase-block models (latency n_*; 0 disables) plus manual done forces
   int   n_init, n_ksa, n_prga;
   int   mc_i, mc_k, mc_p;
   logic m_init_done, m_ksa_done, m_prga_done;
   logic f_init, f_ksa, f_prga;

   assign init_done = m_init_done | f_init;
   assign ksa_done  = m_ksa_done  | f_ksa;
   assign prga_done = m_prga_done | f_prga;

   always @(posedge clk) begin
      if (sub_reset) begin
         mc_i <= 0; mc_k <= 0; mc_p <= 0;
         m_init_done <= 1'b0; m_ksa_done <= 1'b0; m_prga_done <= 1'b0;
      end else begin
         if (init_start && !m_init_done && n_init > 1) begin
            mc_i <= mc_i + 1;
            if (mc_i + 1 == n_init - 1) m_init_done <= 1'b1;
         end
         if (ksa_start && !m_ksa_done && n_ksa > 1) begin
            mc_k <= mc_k + 1;
            if (mc_k + 1 == n_ksa - 1) m_ksa_done <= 1'b1;
         end
         if (prga_start && !m_prga_done && n_prga > 1) begin
            mc_p <= mc_p + 1;
            if (mc_p + 1 == n_prga - 1) m_prga_done <= 1'b1;
         end
      end
   end

   rc4_phase_controller u_dut (
      .clk(clk), .reset_n(reset_n), .start(start), .sub_reset(sub_reset),
      .init_start(init_start), .ksa_start(ksa_start), .prga_start(prga_start),
      .init_done(init_done), .ksa_done(ksa_done), .prga_done(prga_done),
      .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
      .init_address(init_address), .ksa_address(ksa_address), .prga_address(prga_address),
      .init_data(init_data), .ksa_data(ksa_data), .prga_data(prga_data),
      .mem_wren(mem_wren), .mem_address(mem_address), .mem_data(mem_data),
      .busy(busy), .done(done), .error(error), .phase(phase)
   );

   rc4_phase_controller #(.TIMEOUT_CYCLES(16'd16)) u_wd (
      .clk(clk), .reset_n(reset_n), .start(start), .sub_reset(wd_sub_reset),
      .init_start(wd_init_start), .ksa_start(wd_ksa_start), .prga_start(wd_prga_start),
      .init_done(wd_init_done), .ksa_done(wd_ksa_done), .prga_done(wd_prga_done),
      .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
      .init_address(init_address), .ksa_address(ksa_address), .prga_address(prga_address),
      .init_data(init_data), .ksa_data(ksa_data), .prga_data(prga_data),
      .mem_wren(wd_mem_wren), .mem_address(wd_mem_address), .mem_data(wd_mem_data),
      .busy(wd_busy), .done(wd_done), .error(wd_error), .phase(wd_phase)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_mux();
      init_wren = 0; ksa_wren = 0; prga_wren = 0;
      init_address = 0; ksa_address = 0; prga_address = 0;
      init_data = 0; ksa_data = 0; prga_data = 0;
   endtask

   task automatic do_reset();
      reset_n = 0; start = 0;
      f_init = 0; f_ksa = 0; f_prga = 0;
      wd_init_done = 0; wd_ksa_done = 0; wd_prga_done = 0;
      n_init = 0; n_ksa = 0; n_prga = 0;
      clr_mux();
      repeat (3) @(posedge clk);
      #1 reset_n = 1;
   endtask

   // Walks the main instance forward one state per cycle until it shows phase ph.
   task automatic advance_to(input logic [2:0] ph);
      for (int i = 0; i < 10; i++) begin
         if (phase == ph) break;
         case (phase)
            3'd0: start = 1;
            3'd2: f_init = 1;
            3'd3: f_ksa = 1;
            3'd4: f_prga = 1;
            default: ;
         endcase
         step();
         start = 0;
      end
   endtask

   typedef struct {
      logic [2:0] ph;
      logic [2:0] wr;   // {prga, ksa, init}
      logic [7:0] a0, a1, a2, d0, d1, d2;
      logic       ew;
      logic [7:0] ea, ed;
   } vec_t;

   vec_t        tv[8];
   logic [2:0]  seq[$];
   logic [2:0]  last;
   logic [2:0]  min_exp[5];
   int          ci, ck, cp, ok, k;
   logic        mux_done;

   initial begin
      tv[0] = '{3'd0, 3'b111, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 1'b0, 8'h00, 8'h00};
      tv[1] = '{3'd2, 3'b111, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 1'b1, 8'h11, 8'h44};
      tv[2] = '{3'd2, 3'b110, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 1'b0, 8'h11, 8'h44};
      tv[3] = '{3'd3, 3'b101, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 1'b0, 8'h22, 8'h55};
      tv[4] = '{3'd3, 3'b010, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 1'b1, 8'h22, 8'h55};
      tv[5] = '{3'd4, 3'b011, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 1'b0, 8'h33, 8'h66};
      tv[6] = '{3'd4, 3'b100, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 1'b1, 8'hC3, 8'hF6};
      tv[7] = '{3'd5, 3'b111, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 1'b0, 8'h00, 8'h00};
      min_exp[0] = 3'd1; min_exp[1] = 3'd2; min_exp[2] = 3'd3; min_exp[3] = 3'd4; min_exp[4] = 3'd5;

      // ---- reset state
      reset_n = 0; start = 0;
      f_init = 0; f_ksa = 0; f_prga = 0;
      wd_init_done = 0; wd_ksa_done = 0; wd_prga_done = 0;
      n_init = 0; n_ksa = 0; n_prga = 0;
      clr_mux();
      #1;
      chk("rst_phase", phase, 0);
      chk("rst_sub_reset", sub_reset, 1);
      chk("rst_starts", {init_start, ksa_start, prga_start}, 0);
      chk("rst_flags", {busy, done, error}, 0);
      chk("rst_mem", {mem_wren, mem_address, mem_data}, 0);
      do_reset();

      // ---- full run 512/1800/300
      n_init = 512; n_ksa = 1800; n_prga = 300;
      seq.delete(); seq.push_back(phase); last = phase;
      ci = 0; ck = 0; cp = 0; mux_done = 0;
      start = 1; step(); start = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (cyc == 0) chk("lat_clear", {phase, sub_reset}, {3'd1, 1'b1});
         if (cyc == 1) chk("lat_init", {phase, init_start}, {3'd2, 1'b1});
         if (phase != last) seq.push_back(phase);
         last = phase;
         if (init_start) ci++;
         if (ksa_start) ck++;
         if (prga_start) cp++;
         if (ci == 100 && !mux_done) begin
            mux_done = 1;
            ksa_wren = 1; ksa_address = 8'h55;
            init_wren = 1; init_address = 8'h10; init_data = 8'h10;
            #1;
            chk("mux_init_owner", {mem_wren, mem_address, mem_data}, {1'b1, 8'h10, 8'h10});
            clr_mux();
         end
         if (phase == 3'd5) break;
         step();
      end
      chk("seq_len", seq.size(), 6);
      for (int i = 0; i < 6 && i < seq.size(); i++) chk($sformatf("seq[%0d]", i), seq[i], i);
      chk("init_cycles", ci, 512);
      chk("ksa_cycles", ck, 1800);
      chk("prga_cycles", cp, 300);
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         if (done && phase == 3'd5 && !busy) ok++;
         step();
      end
      chk("done_holds", ok, 20);

      // ---- table: mux in each state
      do_reset();
      for (int i = 0; i < 8; i++) begin
         advance_to(tv[i].ph);
         init_wren = tv[i].wr[0]; ksa_wren = tv[i].wr[1]; prga_wren = tv[i].wr[2];
         init_address = tv[i].a0; ksa_address = tv[i].a1; prga_address = tv[i].a2;
         init_data = tv[i].d0; ksa_data = tv[i].d1; prga_data = tv[i].d2;
         #1;
         chk($sformatf("tv%0d_phase", i), phase, tv[i].ph);
         chk($sformatf("tv%0d_mem", i), {mem_wren, mem_address, mem_data},
             {tv[i].ew, tv[i].ea, tv[i].ed});
      end
      clr_mux();

      // ---- stale init_done into KSA, start ignored while busy, async reset mid-PRGA
      do_reset();
      advance_to(3'd3);
      repeat (3) step();
      start = 1; step(); start = 0;
      chk("busy_start_ignored", {phase, sub_reset}, {3'd3, 1'b0});
      repeat (8) step();
      chk("stale_done_stays_ksa", phase, 3);
      f_ksa = 1; step();
      chk("handoff_prga", {phase, ksa_start, prga_start, init_start}, {3'd4, 1'b0, 1'b1, 1'b0});
      prga_wren = 1; prga_address = 8'h77; prga_data = 8'h5A;
      #1;
      chk("prga_write", {mem_wren, mem_address, mem_data}, {1'b1, 8'h77, 8'h5A});
      #1 reset_n = 0;
      #1;
      chk("async_rst", {mem_wren, phase, sub_reset, prga_start}, {1'b0, 3'd0, 1'b1, 1'b0});
      f_init = 0; f_ksa = 0; f_prga = 0; clr_mux();
      step(); step();
      reset_n = 1;
      repeat (5) step();
      chk("idle_after_rst", {phase, busy}, {3'd0, 1'b0});

      // ---- minimum run, then rerun from DONE
      f_init = 1; f_ksa = 1; f_prga = 1;
      start = 1; step(); start = 0;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("min_run_c%0d", i + 1), phase, min_exp[i]);
         if (i < 4) step();
      end
      f_init = 0; f_ksa = 0; f_prga = 0;
      step();
      start = 1; step(); start = 0;
      chk("rerun_clear", {phase, sub_reset, init_start}, {3'd1, 1'b1, 1'b0});
      step();
      chk("rerun_init", {phase, init_start, sub_reset}, {3'd2, 1'b1, 1'b0});
      step();
      chk("rerun_init_hold", phase, 2);

      // ---- watchdog (TIMEOUT_CYCLES=16 instance)
      do_reset();
      start = 1; step(); start = 0;
      for (int i = 0; i < 10 && wd_phase != 3'd2; i++) step();
      wd_init_done = 1; step();
      ksa_wren = 1; ksa_address = 8'h3C;
      k = 0;
      while (wd_phase == 3'd3 && k < 100) begin
         k++;
         step();
      end
      chk("wd_ksa_cycles", k, 16);
      chk("wd_error", {wd_phase, wd_error, wd_mem_wren, wd_busy}, {3'd6, 1'b1, 1'b0, 1'b0});
      repeat (3) step();
      chk("wd_error_holds", wd_phase, 6);
      wd_init_done = 0;
      start = 1; step(); start = 0;
      chk("wd_restart_clear", {wd_phase, wd_sub_reset}, {3'd1, 1'b1});
      step();
      chk("wd_restart_init", {wd_phase, wd_init_start}, {3'd2, 1'b1});
      repeat (15) step();
      wd_init_done = 1;
      #1;
      chk("wd_init_last_cycle", wd_phase, 2);
      step();
      chk("wd_done_beats_timeout", {wd_phase, wd_error}, {3'd3, 1'b0});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/rc4_phase_controller.md
# rc4_phase_controller

Top-level sequencer for the RC4 decryption datapath. Runs the three S-memory phases in order (S init, key-scheduling, PRGA/decrypt) with level start/done handshakes, and gives exactly one phase at a time ownership of the single-port S memory. It also clears the phase blocks between runs and runs a per-phase watchdog. It sits between the top-level control (switches/FSM) and the init, KSA and PRGA blocks, and drives the S-memory port directly.

## Interface
- TIMEOUT_CYCLES, 16'd4095, maximum cycles a phase may run before the error state; 0 disables the watchdog.
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level request to begin a run; sampled in IDLE, DONE and ERROR only.
- sub_reset  out  1  synchronous active-high reset to the init, KSA and PRGA blocks.
- init_start, ksa_start, prga_start  out  1 each  level start to each phase block, held for the whole phase.
- init_done, ksa_done, prga_done  in  1 each  sticky done from each phase block.
- init_wren, ksa_wren, prga_wren  in  1 each  phase write-enable requests.
- init_address, ksa_address, prga_address  in  8 each  phase S addresses.
- init_data, ksa_data, prga_data  in  8 each  phase S write data.
- mem_wren  out  1  S-memory write enable.
- mem_address  out  8  S-memory address.
- mem_data  out  8  S-memory write data.
- busy  out  1  high in CLEAR, INIT, KSA and PRGA.
- done  out  1  high in DONE.
- error  out  1  high in ERROR.
- phase  out  3  state code: IDLE=0, CLEAR=1, INIT=2, KSA=3, PRGA=4, DONE=5, ERROR=6.

## Operation
- State machine states: IDLE, CLEAR, INIT, KSA, PRGA, DONE, ERROR. The state is registered; every output decodes combinationally from the registered state.
- IDLE: sub_reset=1. start=1 -> CLEAR.
- CLEAR: sub_reset=1 for exactly one cycle. Always -> INIT. Phase counter cleared.
- INIT: init_start=1; memory owner is init. init_done=1 -> KSA.
- KSA: ksa_start=1; memory owner is KSA. ksa_done=1 -> PRGA.
- PRGA: prga_start=1; memory owner is PRGA. prga_done=1 -> DONE.
- DONE: done=1; stays in DONE. start=1 -> CLEAR. This is a rerun; phase blocks are not re-entered until cleared.
- ERROR: error=1; stays in ERROR. start=1 -> CLEAR.
- Only the done input of the current phase is examined. Done inputs from earlier phases are ignored even if still high.
- Memory mux: the owner's wren, address and data pass through. In IDLE, CLEAR, DONE and ERROR the mux drives mem_wren=0, mem_address=0 and mem_data=0. A non-owner's wren never reaches memory.
- Watchdog: a 16-bit phase counter clears on every phase entry and increments each cycle in INIT, KSA and PRGA.
  - If the counter reaches TIMEOUT_CYCLES in a cycle where the current done input is low, the next state is ERROR.
  - If done and the timeout occur in the same cycle, done wins.
  - The counter saturates and does not wrap.
- A start asserted while busy is ignored and has no queued effect.

## Timing
- Async reset: while reset_n=0, the state forces to IDLE immediately (no clock needed) and the counter is 0.
  - Output values in reset: sub_reset=1; all *_start=0; mem_wren=0, mem_address=0, mem_data=0; busy=0, done=0, error=0; phase=0.
- Reset asserted mid-phase: memory writes stop in the same cycle and the run is abandoned. After reset_n releases, start is required again.
- Start latency: start sampled high at edge N gives CLEAR in cycle N+1 and INIT (init_start=1) from cycle N+2.
- Phase handoff: the current phase's done sampled high at edge M gives the next phase's start and memory ownership from cycle M+1. No cycle has two owners.
- A phase entered with its done already high (a fault case) advances after one cycle.
- Minimum run: 5 cycles from start to done (CLEAR, then INIT, KSA and PRGA of one cycle each).

## Test plan
- Reset, then start=1 for one cycle; phase blocks return done after 512, 1800 and 300 cycles -> phase sequence 0,1,2,3,4,5; done=1 and stays high; init_start is high for exactly 512 cycles.
- During INIT drive ksa_wren=1, ksa_address=8'h55 and init_wren=1, init_address=8'h10, init_data=8'h10 -> mem_address=8'h10, mem_data=8'h10, mem_wren=1; ksa values never appear at the memory.
- TIMEOUT_CYCLES=16, ksa_done held low -> ERROR exactly 16 cycles after KSA entry; error=1 and mem_wren=0. Then start=1 -> CLEAR with sub_reset=1, and the run restarts.
- init_done held high (stale) into KSA with ksa_done=0 -> remains in KSA; no early PRGA.
- reset_n pulsed low in mid-PRGA while prga_wren=1 -> mem_wren=0 asynchronously and phase=0; the state stays IDLE until start.
- From DONE, start=1 -> one CLEAR cycle (sub_reset=1), then INIT; a start pulse during KSA is ignored (no CLEAR).
